// File: rtl/upgrade_manager.sv
// upgrade_manager: N-channel power-up spawn/emerge/walk/pickup engine with priority-muxed sprite hit
module upgrade_manager #(
  parameter int NUM_UPG    = 4,
  parameter int SPR_SIZE   = 16,
  parameter int WALK_SPEED = 1,
  parameter int X_MIN      = 0,
  parameter int X_MAX      = 623
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 frame_clk,
  input  logic [9:0]           DrawX,
  input  logic [9:0]           DrawY,
  input  logic [2:0]           level_num,
  input  logic [3*NUM_UPG-1:0] cfg_level,
  input  logic [10*NUM_UPG-1:0] cfg_x,
  input  logic [10*NUM_UPG-1:0] cfg_y,
  input  logic [NUM_UPG-1:0]   block_empty,
  input  logic [9:0]           mario_x,
  input  logic [9:0]           mario_y,
  input  logic [9:0]           luigi_x,
  input  logic [9:0]           luigi_y,
  input  logic [9:0]           mario_Size_Y,
  input  logic [9:0]           luigi_Size_Y,
  output logic                 is_upgrade,
  output logic [2:0]           upgrade_sel,
  output logic [8:0]           upgrade_address,
  output logic                 mario_grant,
  output logic                 luigi_grant,
  output logic [2:0]           grant_id,
  output logic [NUM_UPG-1:0]   active_mask
);
  typedef enum logic [1:0] {HIDDEN, EMERGE, WALK, TAKEN} st_t;
  st_t st [NUM_UPG];
  logic [9:0] px [NUM_UPG];
  logic [9:0] py [NUM_UPG];
  logic [4:0] cnt [NUM_UPG];
  logic [9:0] dx [NUM_UPG];
  logic [9:0] dy [NUM_UPG];
  logic [NUM_UPG-1:0] dir, be_q, lvl_ok, hit_m, hit_l, vis;
  logic [2:0] fs;
  logic tick, win_v;
  logic [2:0] win;
  assign tick = fs[1] & ~fs[2];
  function automatic logic overlap(input logic [9:0] x, y, bx, by, bh);
    return {1'b0, x} < {1'b0, bx} + 11'd16 && {1'b0, bx} < {1'b0, x} + 11'(SPR_SIZE) &&
           {1'b0, y} < {1'b0, by} + {1'b0, bh} && {1'b0, by} < {1'b0, y} + 11'(SPR_SIZE);
  endfunction
  always_comb begin
    for (int i = 0; i < NUM_UPG; i++) begin
      lvl_ok[i]      = cfg_level[3*i +: 3] == level_num;
      active_mask[i] = st[i] == EMERGE || st[i] == WALK;
      hit_m[i]       = st[i] == WALK && lvl_ok[i] && overlap(px[i], py[i], mario_x, mario_y, mario_Size_Y);
      hit_l[i]       = st[i] == WALK && lvl_ok[i] && overlap(px[i], py[i], luigi_x, luigi_y, luigi_Size_Y);
      dx[i]          = DrawX - px[i];
      dy[i]          = DrawY - py[i];
      // while emerging, rows still inside the question block are hidden
      vis[i]         = active_mask[i] && lvl_ok[i] && dx[i] < 10'(SPR_SIZE) && dy[i] < 10'(SPR_SIZE) &&
                       (st[i] == WALK || {1'b0, py[i]} + {1'b0, dy[i]} < {1'b0, cfg_y[10*i +: 10]});
    end
  end
  always_comb begin
    win = '0;
    win_v = 1'b0;
    is_upgrade = 1'b0;
    upgrade_sel = '0;
    upgrade_address = '0;
    for (int i = NUM_UPG - 1; i >= 0; i--) begin
      if (hit_m[i] || hit_l[i]) begin
        win = 3'(i);
        win_v = 1'b1;
      end
      if (vis[i]) begin
        is_upgrade = 1'b1;
        upgrade_sel = 3'(i);
        upgrade_address = 9'(dy[i] * SPR_SIZE + dx[i]);
      end
    end
  end
  always_ff @(posedge Clk) begin
    be_q <= block_empty;
    if (Reset) begin
      fs <= '0;
      mario_grant <= 1'b0;
      luigi_grant <= 1'b0;
      grant_id <= '0;
      dir <= '1;
      for (int i = 0; i < NUM_UPG; i++) begin
        st[i] <= HIDDEN;
        px[i] <= cfg_x[10*i +: 10];
        py[i] <= cfg_y[10*i +: 10];
        cnt[i] <= '0;
      end
    end else begin
      fs <= {fs[1:0], frame_clk};
      mario_grant <= tick && win_v && hit_m[win];
      luigi_grant <= tick && win_v && !hit_m[win];
      grant_id <= tick && win_v ? win : 3'd0;
      for (int i = 0; i < NUM_UPG; i++) begin
        if ((st[i] == EMERGE || st[i] == WALK) && !lvl_ok[i]) begin
          st[i] <= HIDDEN;
          px[i] <= cfg_x[10*i +: 10];
          py[i] <= cfg_y[10*i +: 10];
          dir[i] <= 1'b1;
          cnt[i] <= '0;
        end else if (st[i] == HIDDEN && block_empty[i] && !be_q[i] && lvl_ok[i]) begin
          st[i] <= EMERGE;
          px[i] <= cfg_x[10*i +: 10];
          py[i] <= cfg_y[10*i +: 10];
          dir[i] <= 1'b1;
          cnt[i] <= '0;
        end else if (tick && st[i] == EMERGE) begin
          py[i] <= py[i] - 10'd1;
          cnt[i] <= cnt[i] + 5'd1;
          if (cnt[i] == 5'(SPR_SIZE - 1)) st[i] <= WALK;
        end else if (tick && st[i] == WALK) begin
          if (win_v && win == 3'(i)) st[i] <= TAKEN;
          else if (dir[i] && {1'b0, px[i]} + 11'(WALK_SPEED) >= 11'(X_MAX)) begin
            px[i] <= 10'(X_MAX);
            dir[i] <= 1'b0;
          end else if (!dir[i] && {1'b0, px[i]} <= 11'(X_MIN + WALK_SPEED)) begin
            px[i] <= 10'(X_MIN);
            dir[i] <= 1'b1;
          end else px[i] <= dir[i] ? px[i] + 10'(WALK_SPEED) : px[i] - 10'(WALK_SPEED);
        end
      end
    end
  end
endmodule

// File: tb/tb_upgrade_manager.sv
// tb_upgrade_manager: directed scenarios checked against a per-channel behavioural model every cycle
module tb_upgrade_manager;
  localparam int N = 4;
  logic Clk = 0, Reset = 1, frame_clk = 0;
  logic [9:0] DrawX = 0, DrawY = 0;
  logic [2:0] level_num = 1;
  logic [3*N-1:0] cfg_level = {3'd2, 3'd1, 3'd1, 3'd1};
  logic [10*N-1:0] cfg_x = {10'd300, 10'd620, 10'd110, 10'd100};
  logic [10*N-1:0] cfg_y = {10'd200, 10'd200, 10'd342, 10'd342};
  logic [N-1:0] block_empty = 0;
  logic [9:0] mario_x = 900, mario_y = 0, luigi_x = 900, luigi_y = 0;
  logic [9:0] mario_Size_Y = 16, luigi_Size_Y = 16;
  logic is_upgrade, mario_grant, luigi_grant;
  logic [2:0] upgrade_sel, grant_id;
  logic [8:0] upgrade_address;
  logic [N-1:0] active_mask;
  int checks = 0, errors = 0;
  int ms[N], mx[N], my[N], md[N], mc[N];
  bit mbe[N];
  bit h[3];
  bit mgm, mgl;
  int mgid;
  int n_m, n_l, n_l0, id_m, id_l;

  upgrade_manager dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .DrawX(DrawX), .DrawY(DrawY),
    .level_num(level_num), .cfg_level(cfg_level), .cfg_x(cfg_x), .cfg_y(cfg_y),
    .block_empty(block_empty), .mario_x(mario_x), .mario_y(mario_y), .luigi_x(luigi_x),
    .luigi_y(luigi_y), .mario_Size_Y(mario_Size_Y), .luigi_Size_Y(luigi_Size_Y),
    .is_upgrade(is_upgrade), .upgrade_sel(upgrade_sel), .upgrade_address(upgrade_address),
    .mario_grant(mario_grant), .luigi_grant(luigi_grant), .grant_id(grant_id),
    .active_mask(active_mask)
  );

  always #5 Clk = ~Clk;

  function automatic int cl(int i); return int'(cfg_level[3*i +: 3]); endfunction
  function automatic int cx(int i); return int'(cfg_x[10*i +: 10]); endfunction
  function automatic int cy(int i); return int'(cfg_y[10*i +: 10]); endfunction
  function automatic bit ov(int x, int y, int bx, int by, int bh);
    return x < bx + 16 && bx < x + 16 && y < by + bh && by < y + 16;
  endfunction

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // model: state 0 hidden, 1 emerge, 2 walk, 3 taken; dir is +1/-1
  initial forever begin
    @(posedge Clk);
    if (Reset) begin
      for (int i = 0; i < N; i++) begin
        ms[i] = 0; mx[i] = cx(i); my[i] = cy(i); md[i] = 1; mc[i] = 0;
      end
      h = '{0, 0, 0};
      mgm = 0; mgl = 0; mgid = 0;
    end else begin
      bit tk, wm;
      int w;
      tk = h[1] && !h[2];
      w = -1; wm = 0;
      for (int i = 0; i < N; i++)
        if (w < 0 && ms[i] == 2 && cl(i) == int'(level_num)) begin
          bit om, ol;
          om = ov(mx[i], my[i], int'(mario_x), int'(mario_y), int'(mario_Size_Y));
          ol = ov(mx[i], my[i], int'(luigi_x), int'(luigi_y), int'(luigi_Size_Y));
          if (om || ol) begin w = i; wm = om; end
        end
      mgm = tk && w >= 0 && wm;
      mgl = tk && w >= 0 && !wm;
      mgid = (tk && w >= 0) ? w : 0;
      for (int i = 0; i < N; i++) begin
        bit lm;
        lm = cl(i) == int'(level_num);
        if ((ms[i] == 1 || ms[i] == 2) && !lm) begin
          ms[i] = 0; mx[i] = cx(i); my[i] = cy(i); md[i] = 1; mc[i] = 0;
        end else if (ms[i] == 0 && block_empty[i] && !mbe[i] && lm) begin
          ms[i] = 1; mx[i] = cx(i); my[i] = cy(i); md[i] = 1; mc[i] = 0;
        end else if (tk && ms[i] == 1) begin
          my[i] -= 1; mc[i] += 1;
          if (mc[i] == 16) ms[i] = 2;
        end else if (tk && ms[i] == 2) begin
          if (w == i) ms[i] = 3;
          else if (md[i] == 1 && mx[i] + 1 >= 623) begin mx[i] = 623; md[i] = -1; end
          else if (md[i] == -1 && mx[i] <= 1) begin mx[i] = 0; md[i] = 1; end
          else mx[i] += md[i];
        end
      end
      h[2] = h[1]; h[1] = h[0]; h[0] = frame_clk;
    end
    for (int i = 0; i < N; i++) mbe[i] = block_empty[i];
  end

  initial forever begin
    int eh, es, ea, em;
    @(posedge Clk);
    #1;
    eh = 0; es = 0; ea = 0; em = 0;
    for (int i = N - 1; i >= 0; i--) begin
      int ddx, ddy;
      ddx = int'(DrawX) - mx[i];
      ddy = int'(DrawY) - my[i];
      if (ms[i] == 1 || ms[i] == 2) em |= 1 << i;
      if ((ms[i] == 1 || ms[i] == 2) && cl(i) == int'(level_num) && ddx >= 0 && ddx < 16 &&
          ddy >= 0 && ddy < 16 && (ms[i] == 2 || int'(DrawY) < cy(i))) begin
        eh = 1; es = i; ea = ddy * 16 + ddx;
      end
    end
    chk("active_mask", int'(active_mask), em);
    chk("mario_grant", int'(mario_grant), int'(mgm));
    chk("luigi_grant", int'(luigi_grant), int'(mgl));
    chk("grant_id", int'(grant_id), mgid);
    chk("both_grants", int'(mario_grant & luigi_grant), 0);
    chk("is_upgrade", int'(is_upgrade), eh);
    chk("upgrade_sel", int'(upgrade_sel), es);
    chk("upgrade_address", int'(upgrade_address), ea);
    if (mario_grant) begin n_m++; id_m = int'(grant_id); end
    if (luigi_grant) begin n_l++; id_l = int'(grant_id); if (grant_id == 0) n_l0++; end
  end

  task automatic frames(int n);
    repeat (n) begin
      frame_clk = 1;
      repeat (3) @(negedge Clk);
      frame_clk = 0;
      repeat (3) @(negedge Clk);
    end
  endtask

  task automatic probe(string nm, int x, int y, int hit, int sel, int addr);
    DrawX = 10'(x); DrawY = 10'(y);
    #1;
    chk({nm, "_hit"}, int'(is_upgrade), hit);
    chk({nm, "_sel"}, int'(upgrade_sel), sel);
    chk({nm, "_addr"}, int'(upgrade_address), addr);
  endtask

  task automatic rst();
    Reset = 1; block_empty = 0;
    mario_x = 900; mario_y = 0; luigi_x = 900; luigi_y = 0;
    n_m = 0; n_l = 0; n_l0 = 0; id_m = -1; id_l = -1;
    repeat (2) @(negedge Clk);
    Reset = 0;
    @(negedge Clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst();
    chk("reset_mask", int'(active_mask), 0);
    probe("reset_pix", 100, 342, 0, 0, 0);
    // ch3 belongs to level 2 and must ignore its edge
    block_empty = 4'b1001;
    repeat (2) @(negedge Clk);
    chk("spawn_mask", int'(active_mask), 1);
    probe("emerge_in_block", 100, 342, 0, 0, 0);
    frames(8);
    probe("emerge8_top", 100, 334, 1, 0, 0);
    probe("emerge8_hidden_row", 100, 342, 0, 0, 0);
    frames(8);
    probe("walk_y326", 100, 326, 1, 0, 0);
    probe("walk_col1", 101, 326, 1, 0, 1);
    frames(1);
    probe("tick17_old_x", 100, 326, 0, 0, 0);
    probe("tick17_x101", 101, 326, 1, 0, 0);
    frames(39);
    probe("x140", 140, 326, 1, 0, 0);
    probe("x139", 139, 326, 0, 0, 0);
    DrawX = 140;
    Reset = 1;
    @(negedge Clk);
    chk("midwalk_reset_mask", int'(active_mask), 0);
    chk("midwalk_reset_hit", int'(is_upgrade), 0);
    chk("midwalk_reset_grant", int'(mario_grant | luigi_grant), 0);

    rst();
    block_empty = 4'b0100;
    frames(18);
    probe("x622", 622, 184, 1, 2, 0);
    frames(1);
    probe("x623", 623, 184, 1, 2, 0);
    probe("x623_left", 622, 184, 0, 0, 0);
    frames(1);
    probe("back_x622", 622, 184, 1, 2, 0);
    probe("back_x622_col15", 637, 184, 1, 2, 15);

    rst();
    block_empty = 4'b0001;
    frames(21);
    probe("x105", 105, 326, 1, 0, 0);
    mario_x = 110; mario_y = 326;
    frames(4);
    chk("pickup_mario_pulses", n_m, 1);
    chk("pickup_mario_id", id_m, 0);
    chk("pickup_luigi_pulses", n_l, 0);
    chk("pickup_mask", int'(active_mask), 0);
    probe("taken_pix", 105, 326, 0, 0, 0);

    rst();
    mario_x = 90; mario_y = 326; luigi_x = 112; luigi_y = 326;
    block_empty = 4'b0011;
    frames(20);
    chk("prio_mario_pulses", n_m, 1);
    chk("prio_mario_id", id_m, 0);
    chk("prio_luigi_ch0", n_l0, 0);
    chk("prio_luigi_pulses", n_l, 1);
    chk("prio_luigi_id", id_l, 1);
    chk("prio_mask", int'(active_mask), 0);

    rst();
    block_empty = 4'b0011;
    frames(22);
    probe("overlap_ch0", 120, 330, 1, 0, 78);
    level_num = 3;
    cfg_level[5:3] = 3'd3;
    repeat (2) @(negedge Clk);
    chk("level_mask", int'(active_mask), 2);
    probe("level_ch1", 120, 330, 1, 1, 68);
    level_num = 1;
    cfg_level[5:3] = 3'd1;
    block_empty = 4'b0010;
    @(negedge Clk);
    block_empty = 4'b0011;
    repeat (2) @(negedge Clk);
    chk("respawn_mask", int'(active_mask), 3);
    probe("respawn_hidden", 100, 341, 0, 0, 0);
    frames(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
